// File: rtl/matmul_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// matmul_seq_ctrl_if
// Handshake and datapath-control bundle between the matrix-multiply sequencer
// and whoever requests a multiply.
//
// Signals:
//   start, abort     requester -> sequencer : begin / cancel a full multiply
//   busy, done       sequencer -> requester : run in progress / run finished
//   read_addr_m1/m2  sequencer -> RAM banks : operand read addresses
//   acc_clr, acc_en  sequencer -> accumulators
//   res_valid        sequencer -> result sink, qualified by res_addr
//   cycle_cnt        sequencer -> requester, only when MATSEQ_CYCLE_CNT_EN
//                    is defined
//
// Modports:
//   master : the requester side (drives start/abort)
//   slave  : the sequencer side (drives everything else)
// -----------------------------------------------------------------------------
interface matmul_seq_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] read_addr_m1;
    logic [ADDR_W-1:0] read_addr_m2;
    logic              acc_clr;
    logic              acc_en;
    logic              res_valid;
    logic [ADDR_W-1:0] res_addr;
`ifdef MATSEQ_CYCLE_CNT_EN
    logic [15:0]       cycle_cnt;
`endif

    modport master (
        output start, abort,
        input  busy, done, read_addr_m1, read_addr_m2,
        input  acc_clr, acc_en, res_valid, res_addr
`ifdef MATSEQ_CYCLE_CNT_EN
        , input cycle_cnt
`endif
    );

    modport slave (
        input  start, abort,
        output busy, done, read_addr_m1, read_addr_m2,
        output acc_clr, acc_en, res_valid, res_addr
`ifdef MATSEQ_CYCLE_CNT_EN
        , output cycle_cnt
`endif
    );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_seq_ctrl
// Sequencer for the complex matrix-multiply datapath. On start it walks every
// result element (i,j): clear accumulators (CLR), issue DIM operand reads
// (RUN), let the multiplier pipeline drain (WAIT), then flag the finished
// element (RES). After the last element it pulses done (DONE).
//
// Ports:
//   clk_fast  system clock
//   rst       asynchronous, active-high reset
//   bus       matmul_seq_ctrl_if.slave (start/abort in; busy, done, read
//             addresses, accumulator controls, result flag/address out)
//
// Optional: define MATSEQ_CYCLE_CNT_EN to add the 16-bit saturating busy
// cycle counter on bus.cycle_cnt.
//
// All outputs are decoded from registered state only, so an asynchronous
// reset forces them to 0 immediately.
// -----------------------------------------------------------------------------
module matmul_seq_ctrl #(
    parameter int DIM      = 3,
    parameter int ADDR_W   = 4,
    parameter int PIPE_LAT = 2
) (
    input  logic           clk_fast,
    input  logic           rst,
    matmul_seq_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(DIM);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIM - 1);
    localparam logic [2:0]        LAST_WAIT = 3'(PIPE_LAT - 1);
    localparam logic [ADDR_W-1:0] DIM_A     = ADDR_W'(DIM);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_RUN, S_WAIT, S_RES, S_DONE
    } state_t;

    state_t            r_state, w_state_next;
    logic [IDX_W-1:0]  r_i, r_j, r_k;
    logic [IDX_W-1:0]  w_i_next, w_j_next, w_k_next;
    logic [2:0]        r_wait, w_wait_next;
    logic [PIPE_LAT-1:0] r_pipe;
    logic              w_issue;
    logic              w_flush;
    logic              w_busy, w_done, w_acc_clr, w_res_valid;
    logic [ADDR_W-1:0] w_addr_m1, w_addr_m2, w_res_addr;

    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_next;
            r_i     <= w_i_next;
            r_j     <= w_j_next;
            r_k     <= w_k_next;
            r_wait  <= w_wait_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_i_next     = r_i;
        w_j_next     = r_j;
        w_k_next     = r_k;
        w_wait_next  = r_wait;
        w_issue      = 1'b0;
        w_flush      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_acc_clr    = 1'b0;
        w_res_valid  = 1'b0;
        w_addr_m1    = '0;
        w_addr_m2    = '0;
        w_res_addr   = '0;

        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort)
                    w_state_next = S_CLR;
            end
            S_CLR: begin
                w_busy       = 1'b1;
                w_acc_clr    = 1'b1;
                w_k_next     = '0;
                w_wait_next  = '0;
                w_state_next = S_RUN;
            end
            S_RUN: begin
                w_busy    = 1'b1;
                w_issue   = 1'b1;
                w_addr_m1 = ADDR_W'(r_i) * DIM_A + ADDR_W'(r_k);
                w_addr_m2 = ADDR_W'(r_k) * DIM_A + ADDR_W'(r_j);
                if (r_k == LAST_IDX) begin
                    w_k_next     = '0;
                    w_state_next = S_WAIT;
                end else begin
                    w_k_next = r_k + 1'b1;
                end
            end
            S_WAIT: begin
                w_busy = 1'b1;
                if (r_wait == LAST_WAIT) begin
                    w_wait_next  = '0;
                    w_state_next = S_RES;
                end else begin
                    w_wait_next = r_wait + 1'b1;
                end
            end
            S_RES: begin
                w_busy      = 1'b1;
                w_res_valid = 1'b1;
                w_res_addr  = ADDR_W'(r_i) * DIM_A + ADDR_W'(r_j);
                if (r_j != LAST_IDX) begin
                    w_j_next     = r_j + 1'b1;
                    w_state_next = S_CLR;
                end else if (r_i != LAST_IDX) begin
                    w_j_next     = '0;
                    w_i_next     = r_i + 1'b1;
                    w_state_next = S_CLR;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_i_next     = '0;
                w_j_next     = '0;
                w_k_next     = '0;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase

        // Abort overrides whatever the state would have done next.
        if (bus.abort && r_state != S_IDLE) begin
            w_state_next = S_IDLE;
            w_i_next     = '0;
            w_j_next     = '0;
            w_k_next     = '0;
            w_wait_next  = '0;
            w_flush      = 1'b1;
        end
    end

    // Issue delay line: acc_en is the issue bit seen PIPE_LAT cycles later,
    // which lines it up with products reaching the accumulator input.
    generate
        for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_pipe
            always_ff @(posedge clk_fast or posedge rst) begin
                if (rst)
                    r_pipe[gi] <= 1'b0;
                else if (w_flush)
                    r_pipe[gi] <= 1'b0;
                else if (gi == 0)
                    r_pipe[gi] <= w_issue;
                else
                    r_pipe[gi] <= r_pipe[(gi == 0) ? 0 : gi - 1];
            end
        end
    endgenerate

    assign bus.busy         = w_busy;
    assign bus.done         = w_done;
    assign bus.acc_clr      = w_acc_clr;
    assign bus.acc_en       = r_pipe[PIPE_LAT-1];
    assign bus.res_valid    = w_res_valid;
    assign bus.res_addr     = w_res_addr;
    assign bus.read_addr_m1 = w_addr_m1;
    assign bus.read_addr_m2 = w_addr_m2;

`ifdef MATSEQ_CYCLE_CNT_EN
    logic [15:0] r_cycle_cnt;

    // Cleared on an accepted start, counts busy cycles, saturates; abort
    // simply stops it because busy drops.
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst)
            r_cycle_cnt <= '0;
        else if (r_state == S_IDLE && bus.start && !bus.abort)
            r_cycle_cnt <= '0;
        else if (w_busy && r_cycle_cnt != 16'hFFFF)
            r_cycle_cnt <= r_cycle_cnt + 16'd1;
    end

    assign bus.cycle_cnt = r_cycle_cnt;
`endif

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
Sequencer for the complex matrix-multiply datapath: RAM banks R1/I1/R2/I2, the four multipliers, the real/imag adders and the accumulators. After the operand matrices are loaded, it walks every result element (i,j). For each element it issues the row/column read addresses, clears the accumulators, and gates accumulation so the pipeline-delayed products are summed. It then flags each finished element with its result address. It replaces the free-running address generator enable with a start/done handshake.

Parameters:
DIM, 3, matrix dimension (square DIMxDIM), legal 2..15
ADDR_W, 4, read/result address width, must satisfy 2^ADDR_W >= DIM*DIM
PIPE_LAT, 2, cycles from read address issue to product valid at accumulator input, legal 1..7

Ports:
clk_fast  in  1  system clock (single clock domain)
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin a full multiply; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE next cycle, no done
busy  out  1  high from first CLR cycle through last RES cycle
done  out  1  one-cycle pulse after last element's RES cycle
read_addr_m1  out  ADDR_W  M1 read address = i*DIM+k
read_addr_m2  out  ADDR_W  M2 read address = k*DIM+j
acc_clr  out  1  synchronous clear of real and imag accumulators
acc_en  out  1  accumulate enable, aligned with product valid
res_valid  out  1  accumulators hold final value of element (i,j)
res_addr  out  ADDR_W  result index i*DIM+j, valid with res_valid

Behaviour:
- Reset (async, rst=1): state IDLE; i=j=k=0; all outputs 0; acc_en delay line cleared.
- States: IDLE, CLR, RUN, WAIT, RES, DONE.
- IDLE: start=1 -> CLR. Otherwise hold. busy=0.
- CLR (1 cycle): acc_clr=1 -> RUN with k=0.
- RUN (DIM cycles): drives read_addr_m1=i*DIM+k and read_addr_m2=k*DIM+j. Pushes 1 into the issue delay line. Increments k. After k=DIM-1 -> WAIT.
- WAIT (PIPE_LAT cycles): no new issue; addresses driven 0 -> RES.
- acc_en = issue bit delayed PIPE_LAT cycles. It is high exactly DIM consecutive cycles, the last coinciding with the final WAIT cycle.
- RES (1 cycle): res_valid=1, res_addr=i*DIM+j.
  - If j<DIM-1: j++.
  - Else if i<DIM-1: j=0, i++.
  - Branch to CLR unless (i,j)=(DIM-1,DIM-1), then DONE.
- DONE (1 cycle): done=1, busy=0, i=j=k=0 -> IDLE.
- Outside RUN, read addresses are 0. Outside CLR/RES, acc_clr and res_valid are 0.
- Cycle count per element: 2+DIM+PIPE_LAT. Full multiply: DIM*DIM*(2+DIM+PIPE_LAT) busy cycles, then 1 DONE cycle.
- start while busy or in DONE: ignored, not queued.
- abort in any non-IDLE state: next state IDLE, indices cleared, delay line flushed. No done, no further res_valid.
- abort and start in the same IDLE cycle: abort wins, stays IDLE.
- Address arithmetic is unsigned, width ADDR_W. Index registers are $clog2(DIM) bits wide and never exceed DIM-1; there is no wrap.
- rst mid-operation: immediate IDLE, all outputs 0, same as power-on.

Optional Feature:
Macro MATSEQ_CYCLE_CNT_EN.
- Defined: adds output cycle_cnt (16 bits). Cleared on accepted start. Increments every busy cycle, saturating at 16'hFFFF. Holds its value after done until the next accepted start. Reset value 0. abort freezes it.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- DIM=3, PIPE_LAT=2, start pulse at cycle 0 -> busy=1 cycles 1..63, acc_clr at cycle 1, done=1 at cycle 64, busy=0 at 64.
- Element (0,0): read_addr_m1 = 0,1,2 and read_addr_m2 = 0,3,6 at cycles 2,3,4. acc_en=1 at cycles 4,5,6. res_valid at cycle 7 with res_addr=0.
- Element (1,2), the 6th element: read_addr_m1 = 3,4,5, read_addr_m2 = 2,5,8. res_valid with res_addr=5 at cycle 42. res_addr over the run = 0..8 in order, exactly 9 res_valid pulses.
- start re-asserted at cycles 10 and 64 -> ignored, no second run, single done. abort at cycle 20 -> busy=0 at 21, no done, no res_valid afterward.
- rst asserted at cycle 30 mid-RUN -> all outputs 0 immediately. Fresh start afterward reproduces the first scenario's timing exactly.
- With MATSEQ_CYCLE_CNT_EN: cycle_cnt=63 after done, holding until next start. A second start clears it to 0, and it reaches 63 again.
